// File: rtl/shf_unit.sv
// Logical barrel shifter with sticky flag for mantissa alignment/normalisation.
// Direction fixed at build time; combinational result plus a registered copy.
module shf_unit #(
  parameter int LEFT_RIGHT = 0,
  parameter int SIZE_DATA  = 24,
  parameter int SIZE_SHIFT = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SIZE_SHIFT-1:0] i_shift_number,
  input  logic [SIZE_DATA-1:0]  i_data,
  output logic [SIZE_DATA-1:0]  o_data,
  output logic                  o_sticky,
  output logic [SIZE_DATA-1:0]  o_data_q,
  output logic                  o_sticky_q
);

  localparam int W = SIZE_DATA;

  logic [W-1:0] stage_data   [0:SIZE_SHIFT];
  logic         stage_sticky [0:SIZE_SHIFT];

  logic [W-1:0] data_d, data_q;
  logic         sticky_d, sticky_q;

  assign stage_data[0]   = i_data;
  assign stage_sticky[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE_SHIFT; gi++) begin : g_stage
      localparam int AMT = 1 << gi;
      logic [W-1:0] shifted;
      logic         lost;

      // A stage whose step covers the whole word discards every bit it sees.
      if (AMT >= W) begin : g_full
        assign shifted = '0;
        assign lost    = |stage_data[gi];
      end else if (LEFT_RIGHT == 0) begin : g_left
        assign shifted = stage_data[gi] << AMT;
        assign lost    = |stage_data[gi][W-1 -: AMT];
      end else begin : g_right
        assign shifted = stage_data[gi] >> AMT;
        assign lost    = |stage_data[gi][AMT-1:0];
      end

      assign stage_data[gi+1]   = i_shift_number[gi] ? shifted : stage_data[gi];
      assign stage_sticky[gi+1] = stage_sticky[gi] | (i_shift_number[gi] & lost);
    end
  endgenerate

  assign o_data   = stage_data[SIZE_SHIFT];
  assign o_sticky = stage_sticky[SIZE_SHIFT];

  assign data_d   = o_data;
  assign sticky_d = o_sticky;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_data_q   = data_q;
  assign o_sticky_q = sticky_q;

endmodule

// File: tb/tb_shf_unit.sv
// Self-checking bench for shf_unit: directed table, random sweep against a
// wide-word reference, registered-path and asynchronous-reset sequences.
module tb_shf_unit;

  localparam int W = 24;
  localparam int S = 5;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [S-1:0] i_shift_number = '0;
  logic [W-1:0] i_data = '0;

  logic [W-1:0] l_data, l_data_q, r_data, r_data_q;
  logic         l_sticky, l_sticky_q, r_sticky, r_sticky_q;

  always #5 i_clk = ~i_clk;

  shf_unit #(.LEFT_RIGHT(0), .SIZE_DATA(W), .SIZE_SHIFT(S)) u_left (
    .i_clk(i_clk), .i_rst(i_rst), .i_shift_number(i_shift_number), .i_data(i_data),
    .o_data(l_data), .o_sticky(l_sticky), .o_data_q(l_data_q), .o_sticky_q(l_sticky_q)
  );

  shf_unit #(.LEFT_RIGHT(1), .SIZE_DATA(W), .SIZE_SHIFT(S)) u_right (
    .i_clk(i_clk), .i_rst(i_rst), .i_shift_number(i_shift_number), .i_data(i_data),
    .o_data(r_data), .o_sticky(r_sticky), .o_data_q(r_data_q), .o_sticky_q(r_sticky_q)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: place the operand in a 64-bit word so nothing is lost by the
  // shift itself; the bits that fall outside the result window are the sticky bits.
  function automatic logic [W:0] ref_shift(input bit right, input logic [W-1:0] d, input int n);
    logic [63:0] wide;
    if (!right) begin
      wide = {40'b0, d} << n;
      return {|wide[63:W], wide[W-1:0]};
    end else begin
      wide = {d, 40'b0} >> n;
      return {|wide[39:0], wide[63:40]};
    end
  endfunction

  typedef struct {
    bit           right;
    logic [W-1:0] data;
    logic [S-1:0] n;
    logic [W-1:0] exp_d;
    logic         exp_s;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit right, input logic [W-1:0] data, input logic [S-1:0] n,
                                  input logic [W-1:0] exp_d, input logic exp_s);
    vec_t v;
    v.right = right; v.data = data; v.n = n; v.exp_d = exp_d; v.exp_s = exp_s;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] got_d;
    logic         got_s;
    bit           right;
    int           n;

    add_vec(1'b0, 24'hABCDEF, 5'd4,  24'hBCDEF0, 1'b1);
    add_vec(1'b0, 24'h0BCDEF, 5'd4,  24'hBCDEF0, 1'b0);
    add_vec(1'b1, 24'hABCDEF, 5'd4,  24'h0ABCDE, 1'b1);
    add_vec(1'b1, 24'h800000, 5'd23, 24'h000001, 1'b0);
    for (int b = 0; b < 2; b++) begin
      add_vec(b[0], 24'h5A5A5A, 5'd0,  24'h5A5A5A, 1'b0);
      add_vec(b[0], 24'h000001, 5'd24, 24'h000000, 1'b1);
      add_vec(b[0], 24'h000001, 5'd31, 24'h000000, 1'b1);
      add_vec(b[0], 24'h000000, 5'd24, 24'h000000, 1'b0);
      add_vec(b[0], 24'h000000, 5'd31, 24'h000000, 1'b0);
    end

    // Reset state before any clock edge
    #1;
    check("reset_l_data_q", l_data_q, 0);
    check("reset_l_sticky_q", l_sticky_q, 0);
    check("reset_r_data_q", r_data_q, 0);
    check("reset_r_sticky_q", r_sticky_q, 0);

    foreach (vecs[i]) begin
      i_data = vecs[i].data;
      i_shift_number = vecs[i].n;
      #1;
      got_d = vecs[i].right ? r_data : l_data;
      got_s = vecs[i].right ? r_sticky : l_sticky;
      $display("[TB] vec %0d dir=%0d data=%h n=%0d -> data=%h sticky=%0b", i, vecs[i].right,
               vecs[i].data, vecs[i].n, got_d, got_s);
      check($sformatf("vec%0d_data", i), got_d, vecs[i].exp_d);
      check($sformatf("vec%0d_sticky", i), got_s, vecs[i].exp_s);
    end

    for (int i = 0; i < 500; i++) begin
      i_data = W'($urandom);
      i_shift_number = S'($urandom_range(0, W - 1));
      #1;
      for (int b = 0; b < 2; b++) begin
        right = b[0];
        exp = ref_shift(right, i_data, int'(i_shift_number));
        got_d = right ? r_data : l_data;
        got_s = right ? r_sticky : l_sticky;
        check($sformatf("rnd%0d_dir%0d_data", i, b), got_d, exp[W-1:0]);
        check($sformatf("rnd%0d_dir%0d_sticky", i, b), got_s, exp[W]);
      end
      $display("[TB] rnd %0d data=%h n=%0d -> L=%h/%0b R=%h/%0b", i, i_data, i_shift_number,
               l_data, l_sticky, r_data, r_sticky);
    end

    // Registered path
    @(negedge i_clk);
    i_rst = 1'b0;
    i_data = 24'h123456;
    i_shift_number = 5'd8;
    @(posedge i_clk); #1;
    $display("[TB] reg n=8 -> data_q=%h sticky_q=%0b", l_data_q, l_sticky_q);
    check("reg_n8_data_q", l_data_q, 24'h345600);
    check("reg_n8_sticky_q", l_sticky_q, 1'b1);
    check("reg_n8_r_data_q", r_data_q, 24'h001234);
    check("reg_n8_r_sticky_q", r_sticky_q, 1'b1);
    @(negedge i_clk);
    i_shift_number = 5'd0;
    @(posedge i_clk); #1;
    $display("[TB] reg n=0 -> data_q=%h sticky_q=%0b", l_data_q, l_sticky_q);
    check("reg_n0_data_q", l_data_q, 24'h123456);
    check("reg_n0_sticky_q", l_sticky_q, 1'b0);

    // Asynchronous reset between edges
    @(negedge i_clk);
    i_shift_number = 5'd4;
    #2 i_rst = 1'b1;
    #1;
    $display("[TB] async reset -> data_q=%h sticky_q=%0b", l_data_q, l_sticky_q);
    check("arst_l_data_q", l_data_q, 0);
    check("arst_l_sticky_q", l_sticky_q, 0);
    check("arst_r_data_q", r_data_q, 0);
    check("arst_comb_unaffected", l_data, 24'h234560);
    repeat (2) @(posedge i_clk);
    #1;
    $display("[TB] held reset -> data_q=%h sticky_q=%0b", l_data_q, l_sticky_q);
    check("hold_l_data_q", l_data_q, 0);
    check("hold_l_sticky_q", l_sticky_q, 0);

    // Release between edges; first edge captures the current result
    @(negedge i_clk);
    i_rst = 1'b0;
    i_data = 24'hABCDEF;
    i_shift_number = 5'd4;
    #1;
    check("release_no_edge_data_q", l_data_q, 0);
    @(posedge i_clk); #1;
    $display("[TB] release -> L=%h/%0b R=%h/%0b", l_data_q, l_sticky_q, r_data_q, r_sticky_q);
    check("release_l_data_q", l_data_q, 24'hBCDEF0);
    check("release_l_sticky_q", l_sticky_q, 1'b1);
    check("release_r_data_q", r_data_q, 24'h0ABCDE);
    check("release_r_sticky_q", r_sticky_q, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
